// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bridge: FSM encoding, page
// register geometry, reset page values and the phase counter width.
package sram_ctrl_pkg;

  localparam int PAGE_BITS = 4;
  localparam int NUM_PAGES = 4;
  localparam int PHASE_W   = 4;
  localparam int SRAM_AW   = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Reset contents give a flat map of the lower 64 KB: page n -> bank n.
  function automatic logic [PAGE_BITS-1:0] page_rst_val(input int idx);
    return PAGE_BITS'(idx);
  endfunction

endpackage

// File: rtl/sram_page_map.sv
// Page register file and CPU-to-SRAM address mapping for sram_ctrl.
// Only built when SRAM_CTRL_PAGING_EN is defined.
`ifdef SRAM_CTRL_PAGING_EN
module sram_page_map
  import sram_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 page_wr,
  input  logic [1:0]           page_sel,
  input  logic [PAGE_BITS-1:0] page_data,
  input  logic [15:0]          cpu_addr,
  output logic [SRAM_AW-1:0]   map_addr
);

  logic [PAGE_BITS-1:0] page_q [NUM_PAGES];
  logic [PAGE_BITS-1:0] page_d [NUM_PAGES];

  // Next page contents: a write strobe replaces the selected bank number.
  always_comb begin
    for (int i = 0; i < NUM_PAGES; i++) begin
      page_d[i] = page_q[i];
    end
    if (page_wr) begin
      page_d[page_sel] = page_data;
    end
  end

  // Page register storage with flat-map reset values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        page_q[i] <= page_rst_val(i);
      end
    end else begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        page_q[i] <= page_d[i];
      end
    end
  end

  // Mapping reads the registered pages, so a coincident write is not seen
  // by a request accepted on the same edge.
  assign map_addr = {page_q[cpu_addr[15:14]], cpu_addr[13:0]};

endmodule
`endif

// File: rtl/sram_ctrl.sv
// Z80 bus to 256Kx8 asynchronous SRAM bridge.
// Sequences CS/OE/WE through SETUP, ACCESS and HOLD phases and returns
// a single-cycle ack. Optional 16 KB paging is enabled by defining
// SRAM_CTRL_PAGING_EN; without it the CPU address maps flat to 0..64K.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic         clk100,
  input  logic         n_reset,
  input  logic         req,
  input  logic         we,
  input  logic [15:0]  cpu_addr,
  input  logic [7:0]   cpu_wdata,
  output logic [7:0]   rdata,
  output logic         ack,
  output logic         busy,
  input  logic         page_wr,
  input  logic [1:0]   page_sel,
  input  logic [3:0]   page_data,
  output logic [17:0]  sramAddress,
  inout  wire  [7:0]   sramData,
  output logic         n_sRamCS,
  output logic         n_sRamOE,
  output logic         n_sRamWE
);

  // Phase counter reload values: the counter counts down to zero, so a
  // state lasting N cycles is entered with N-1.
  localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] ACCESS_LD = PHASE_W'(ACCESS_CYC - 1);
  localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYC - 1);

  logic [SRAM_AW-1:0] map_addr;

`ifdef SRAM_CTRL_PAGING_EN
  sram_page_map u_page_map (
    .clk       (clk100),
    .n_reset   (n_reset),
    .page_wr   (page_wr),
    .page_sel  (page_sel),
    .page_data (page_data),
    .cpu_addr  (cpu_addr),
    .map_addr  (map_addr)
  );
`else
  // Paging inputs have no function in the flat build.
  logic unused_page_in;
  assign unused_page_in = ^{page_wr, page_sel, page_data};
  assign map_addr = {2'b00, cpu_addr};
`endif

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 we_q, we_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 n_cs_q, n_cs_d;
  logic                 n_oe_q, n_oe_d;
  logic                 n_we_q, n_we_d;
  logic                 drv_q, drv_d;

  // Next-state, phase counting, request latching and registered strobes.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The ack cycle is spent in IDLE; a req still held during it
        // starts the next transfer on the edge that ends the ack cycle.
        if (req) begin
          state_d = ST_SETUP;
          phase_d = SETUP_LD;
          we_d    = we;
          wdata_d = cpu_wdata;
          addr_d  = map_addr;
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          state_d = ST_ACCESS;
          phase_d = ACCESS_LD;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      ST_ACCESS: begin
        if (phase_q == '0) begin
          state_d = ST_HOLD;
          phase_d = HOLD_LD;
          if (!we_q) begin
            rdata_d = sramData;
          end
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_q == '0) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they change exactly on
    // the state-transition edge and leave the flops glitch-free.
    n_cs_d = (state_d == ST_IDLE);
    n_oe_d = !((state_d == ST_ACCESS) && !we_d);
    n_we_d = !((state_d == ST_ACCESS) && we_d);
    drv_d  = we_d && (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE) || ack_d;
  end

  // Control, strobe and datapath registers; reset aborts any transfer.
  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      n_cs_q  <= 1'b1;
      n_oe_q  <= 1'b1;
      n_we_q  <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      n_cs_q  <= n_cs_d;
      n_oe_q  <= n_oe_d;
      n_we_q  <= n_we_d;
      drv_q   <= drv_d;
    end
  end

  assign sramData    = drv_q ? wdata_q : 8'bz;
  assign sramAddress = addr_q;
  assign n_sRamCS    = n_cs_q;
  assign n_sRamOE    = n_oe_q;
  assign n_sRamWE    = n_we_q;
  assign rdata       = rdata_q;
  assign ack         = ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: table-driven transfers with a
// scoreboard, plus hand sequences for write hold, reset abort and
// back-to-back requests on a second instance with longer phases.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (default timing) ----------------
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  rdata;
  logic        ack, busy;
  logic        page_wr = 1'b0;
  logic [1:0]  page_sel = '0;
  logic [3:0]  page_data = '0;
  logic [17:0] sram_addr;
  wire  [7:0]  sram_data;
  logic        n_cs, n_oe, n_we;

  sram_ctrl u_dut (
    .clk100(clk), .n_reset(n_reset), .req(req), .we(we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .rdata(rdata),
    .ack(ack), .busy(busy), .page_wr(page_wr), .page_sel(page_sel),
    .page_data(page_data), .sramAddress(sram_addr), .sramData(sram_data),
    .n_sRamCS(n_cs), .n_sRamOE(n_oe), .n_sRamWE(n_we)
  );

  // SRAM model: floating bus reads 0xFF through pull-ups.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (sram_data[i]);
  end
  logic [7:0]  mem [0:262143];
  assign sram_data = (!n_cs && !n_oe) ? mem[sram_addr] : 8'bz;
  logic [17:0] wr_addr_seen = '0;
  logic [7:0]  wr_data_seen = '0;
  always @(posedge n_we) begin
    if (!n_cs) begin
      mem[sram_addr] = sram_data;
      wr_addr_seen   = sram_addr;
      wr_data_seen   = sram_data;
    end
  end

  // ---------------- DUT 2 (SETUP=2, ACCESS=4, HOLD=2) ----------------
  logic        req2 = 1'b0;
  logic [7:0]  rdata2;
  logic        ack2, busy2;
  logic [17:0] sram_addr2;
  wire  [7:0]  sram_data2;
  logic        n_cs2, n_oe2, n_we2;
  logic        tie_we2 = 1'b1;
  logic [15:0] tie_addr2 = 16'h0100;
  logic [7:0]  tie_wdata2 = 8'h42;
  logic        tie_pw = 1'b0;
  logic [1:0]  tie_ps = '0;
  logic [3:0]  tie_pd = '0;

  sram_ctrl #(.SETUP_CYC(2), .ACCESS_CYC(4), .HOLD_CYC(2)) u_dut2 (
    .clk100(clk), .n_reset(n_reset), .req(req2), .we(tie_we2),
    .cpu_addr(tie_addr2), .cpu_wdata(tie_wdata2), .rdata(rdata2),
    .ack(ack2), .busy(busy2), .page_wr(tie_pw), .page_sel(tie_ps),
    .page_data(tie_pd), .sramAddress(sram_addr2), .sramData(sram_data2),
    .n_sRamCS(n_cs2), .n_sRamOE(n_oe2), .n_sRamWE(n_we2)
  );
  for (genvar i = 0; i < 8; i++) begin : g_pu2
    pullup (sram_data2[i]);
  end

  // ---------------- reference model and scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [3:0] shadow_pg [4];
  logic [7:0] ref_mem [logic [17:0]];

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          do_req;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          pg_wr;
    logic [1:0]  pg_sel;
    logic [3:0]  pg_data;
    int          exp_lat;
  } vec_t;
  vec_t vecs [9];

  function automatic logic [17:0] model_map(input logic [15:0] a);
`ifdef SRAM_CTRL_PAGING_EN
    return {shadow_pg[a[15:14]], a[13:0]};
`else
    return {2'b00, a};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < 4; i++) shadow_pg[i] = 4'(i);
  endtask

  task automatic page_only(input logic [1:0] sel, input logic [3:0] data);
    @(posedge clk); #1;
    page_wr = 1'b1; page_sel = sel; page_data = data;
    @(posedge clk); #1;
    page_wr = 1'b0;
    shadow_pg[sel] = data;
  endtask

  task automatic do_xfer(input bit w, input logic [15:0] a, input logic [7:0] d,
                         input bit pw, input logic [1:0] ps, input logic [3:0] pd,
                         input int exp_lat);
    exp_t e, got;
    int   lat;
    @(posedge clk); #1;
    req = 1'b1; we = w; cpu_addr = a; cpu_wdata = d;
    page_wr = pw; page_sel = ps; page_data = pd;
    e.we   = w;
    e.addr = model_map(a);
    if (w) ref_mem[e.addr] = d;
    e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : 8'h00;
    sb.push_back(e);
    if (pw) shadow_pg[ps] = pd;
    @(posedge clk); #1;
    req = 1'b0; page_wr = 1'b0;
    check("busy_on_accept", busy, 1);
    check("sram_addr", sram_addr, e.addr);
    check("cs_on_accept", n_cs, 0);
    lat = 0;
    while (!ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ack_latency", lat, exp_lat);
    got = sb.pop_front();
    if (got.we) begin
      check("wr_addr", wr_addr_seen, got.addr);
      check("wr_data", wr_data_seen, got.data);
    end else begin
      check("rdata", rdata, got.data);
    end
    @(posedge clk); #1;
    check("ack_one_cycle", ack, 0);
    check("busy_after_ack", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int ack_seen;
    int viol;
    bit started;
    int ack_cyc[$];

    reset_shadow();
    mem[18'h00010] = 8'h3C; ref_mem[18'h00010] = 8'h3C;
    mem[18'h14010] = 8'hC3; ref_mem[18'h14010] = 8'hC3;

    vecs[0] = '{1'b1, 1'b1, 16'h1234, 8'h5A, 1'b0, 2'd0, 4'h0, 5};
    vecs[1] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 2'd0, 4'h0, 5};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 2'd3, 4'hF, 0};
    vecs[3] = '{1'b1, 1'b1, 16'hC001, 8'hA5, 1'b0, 2'd0, 4'h0, 5};
    vecs[4] = '{1'b1, 1'b1, 16'h4001, 8'h11, 1'b0, 2'd0, 4'h0, 5};
    vecs[5] = '{1'b1, 1'b0, 16'hC001, 8'h00, 1'b0, 2'd0, 4'h0, 5};
    vecs[6] = '{1'b1, 1'b0, 16'h4001, 8'h00, 1'b0, 2'd0, 4'h0, 5};
    vecs[7] = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 2'd0, 4'h5, 5};
    vecs[8] = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 2'd0, 4'h0, 5};

    // Reset values
    #2 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", n_cs, 1);
    check("rst_oe", n_oe, 1);
    check("rst_we", n_we, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_bus", sram_data, 8'hFF);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_req)
        do_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pg_wr,
                vecs[i].pg_sel, vecs[i].pg_data, vecs[i].exp_lat);
      else
        page_only(vecs[i].pg_sel, vecs[i].pg_data);
    end

    // Write data hold around the WE rising edge
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h77;
    ref_mem[model_map(16'h2000)] = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (n_we && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_we_low", n_we, 0);
    n = 0;
    while (!n_we && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_we_high", n_we, 1);
    check("hold_data", sram_data, 8'h77);
    check("hold_cs", n_cs, 0);
    @(posedge clk); #1;
    check("hold_release_bus", sram_data, 8'hFF);
    check("hold_release_cs", n_cs, 1);
    check("hold_ack", ack, 1);
    check("hold_mem", wr_data_seen, 8'h77);
    @(posedge clk); #1;

    // Reset during ACCESS of a write
    req = 1'b1; we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h99;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (n_we && n < 20) begin @(posedge clk); #1; n++; end
    check("abort_in_access", n_we, 0);
    #2 n_reset = 1'b0;
    #1;
    check("abort_we", n_we, 1);
    check("abort_cs", n_cs, 1);
    check("abort_oe", n_oe, 1);
    check("abort_bus", sram_data, 8'hFF);
    check("abort_busy", busy, 0);
    check("abort_addr", sram_addr, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    reset_shadow();
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack) ack_seen++;
    end
    check("abort_no_ack", ack_seen, 0);
    // Page registers are back to the flat map after reset
    do_xfer(1'b0, 16'h0010, 8'h00, 1'b0, 2'd0, 4'h0, 5);

    // Back-to-back on the long-phase instance with req held high
    @(posedge clk); #1;
    req2 = 1'b1;
    viol = 0;
    started = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (!n_oe2) viol++;
      if (!n_we2 && n_cs2) viol++;
      if (started && (n_cs2 != ack2)) viol++;
      if (ack2) begin
        ack_cyc.push_back(c);
        started = 1'b1;
      end
    end
    req2 = 1'b0;
    check("b2b_strobe_overlap", viol, 0);
    check("b2b_ack_count", ack_cyc.size(), 6);
    if (ack_cyc.size() > 0) check("b2b_first_ack", ack_cyc[0], 9);
    for (int i = 1; i < ack_cyc.size(); i++) begin
      check("b2b_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
